// File: rtl/frame_uploader.sv
// frame_uploader: drains a 17-bit pixel/marker queue and writes each run of
// 16 pixels to memory as one 8-word burst, padding the last burst of a frame
// with zeros when needed.
// Optional build macro: FRAME_UPLOADER_CHECK_EN enables the frame_error
// protocol checks. When it is undefined, frame_error is held at 0.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | no frame open; pop entries looking for a frame start
// S_FETCH      | frame open; pop the next entry when the queue has one
// S_DECODE     | wait one cycle for queue data, then decode the entry
// S_WRITE_REQ  | buffer full; hold write_rq until write_ack
// S_WRITE_DATA | stream the 8 burst words with mem_wr_en
// S_FLUSH      | zero-pad a partial buffer before the final burst
// S_DONE       | pulse upload_done, close the frame
module frame_uploader #(
  parameter int MEMORY_BURST = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] base_addr,
  input  logic        queue_empty,
  input  logic [16:0] queue_data_i,
  output logic        queue_rd_en,
  output logic        write_rq,
  input  logic        write_ack,
  output logic [20:0] write_addr,
  output logic [31:0] write_data,
  output logic        mem_wr_en,
  output logic        upload_done,
  output logic        frame_error
);

  localparam int PIX_PER_BURST = MEMORY_BURST / 2;
  localparam int WORDS         = MEMORY_BURST / 4;
  localparam int IDX_W         = $clog2(PIX_PER_BURST);
  localparam int WCNT_W        = $clog2(WORDS + 1);
  localparam int COL_W         = $clog2(FRAME_WIDTH + 2);
  localparam int ROW_W         = $clog2(FRAME_HEIGHT + 1) + 1;

  localparam logic [16:0] MK_FRAME_START = 17'h10000;
  localparam logic [16:0] MK_ROW_START   = 17'h10001;
  localparam logic [16:0] MK_FRAME_END   = 17'h1FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WRITE_REQ,
    S_WRITE_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic                         active_q, active_d;
  logic                         dec_wait_q, dec_wait_d;
  logic                         flush_q, flush_d;
  logic                         rd_en_q, rd_en_d;
  logic                         write_rq_q, write_rq_d;
  logic                         mem_wr_en_q, mem_wr_en_d;
  logic [31:0]                  write_data_q, write_data_d;
  logic                         upload_done_q, upload_done_d;
  logic                         frame_error_q, frame_error_d;
  logic [20:0]                  addr_q, addr_d;
  logic [IDX_W-1:0]             pix_idx_q, pix_idx_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [WCNT_W-1:0]            word_q, word_d;
  logic [16*PIX_PER_BURST-1:0]  pix_buf_q, pix_buf_d;

  assign queue_rd_en = rd_en_q;
  assign write_rq    = write_rq_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign write_data  = write_data_q;
  assign write_addr  = addr_q;
  assign upload_done = upload_done_q;
  assign frame_error = frame_error_q;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    dec_wait_d    = dec_wait_q;
    flush_d       = flush_q;
    rd_en_d       = 1'b0;
    write_rq_d    = write_rq_q;
    mem_wr_en_d   = mem_wr_en_q;
    write_data_d  = write_data_q;
    upload_done_d = 1'b0;
    frame_error_d = frame_error_q;
    addr_d        = addr_q;
    pix_idx_d     = pix_idx_q;
    col_d         = col_q;
    row_d         = row_q;
    word_d        = word_q;
    pix_buf_d     = pix_buf_q;

    case (state_q)
      S_IDLE, S_FETCH: begin
        if (!queue_empty) begin
          rd_en_d    = 1'b1;
          dec_wait_d = 1'b1;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        if (dec_wait_q) begin
          // queue data lands one cycle after the pop
          dec_wait_d = 1'b0;
        end else begin
          state_d = active_q ? S_FETCH : S_IDLE;
          if (queue_data_i == MK_FRAME_START) begin
            // also restarts a frame already in progress
            active_d      = 1'b1;
            addr_d        = base_addr;
            pix_idx_d     = '0;
            col_d         = '0;
            row_d         = '0;
            pix_buf_d     = '0;
            flush_d       = 1'b0;
            frame_error_d = 1'b0;
            state_d       = S_FETCH;
          end else if (!active_q) begin
            state_d = S_IDLE;
          end else if (queue_data_i == MK_ROW_START) begin
            if (col_q != '0) row_d = row_q + ROW_W'(1);
            col_d = '0;
`ifdef FRAME_UPLOADER_CHECK_EN
            if (col_q != '0 && col_q != COL_W'(FRAME_WIDTH)) frame_error_d = 1'b1;
`endif
          end else if (queue_data_i == MK_FRAME_END) begin
`ifdef FRAME_UPLOADER_CHECK_EN
            if ((row_q + ROW_W'(1)) != ROW_W'(FRAME_HEIGHT)) frame_error_d = 1'b1;
`endif
            if (pix_idx_q == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FLUSH;
            end
          end else if (queue_data_i[16]) begin
            // unknown marker: dropped
`ifdef FRAME_UPLOADER_CHECK_EN
            frame_error_d = 1'b1;
`endif
          end else begin
            pix_buf_d[16*pix_idx_q +: 16] = queue_data_i[15:0];
            if (col_q != '1) col_d = col_q + COL_W'(1);
`ifdef FRAME_UPLOADER_CHECK_EN
            if (col_q >= COL_W'(FRAME_WIDTH)) frame_error_d = 1'b1;
`endif
            if (pix_idx_q == IDX_W'(PIX_PER_BURST - 1)) begin
              write_rq_d = 1'b1;
              state_d    = S_WRITE_REQ;
            end else begin
              pix_idx_d = pix_idx_q + IDX_W'(1);
            end
          end
        end
      end

      S_FLUSH: begin
        for (int i = 0; i < PIX_PER_BURST; i++) begin
          if (IDX_W'(i) >= pix_idx_q) pix_buf_d[16*i +: 16] = 16'h0000;
        end
`ifdef FRAME_UPLOADER_CHECK_EN
        frame_error_d = 1'b1;
`endif
        flush_d    = 1'b1;
        write_rq_d = 1'b1;
        state_d    = S_WRITE_REQ;
      end

      S_WRITE_REQ: begin
        if (write_ack) begin
          mem_wr_en_d  = 1'b1;
          write_data_d = pix_buf_q[31:0];
          word_d       = WCNT_W'(1);
          state_d      = S_WRITE_DATA;
        end
      end

      S_WRITE_DATA: begin
        if (word_q == WCNT_W'(WORDS)) begin
          mem_wr_en_d = 1'b0;
          write_rq_d  = 1'b0;
          addr_d      = addr_q + 21'(PIX_PER_BURST);
          pix_idx_d   = '0;
          word_d      = '0;
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          write_data_d = pix_buf_q[32*word_q +: 32];
          word_d       = word_q + WCNT_W'(1);
        end
      end

      S_DONE: begin
        upload_done_d = 1'b1;
        active_d      = 1'b0;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      active_q      <= 1'b0;
      dec_wait_q    <= 1'b0;
      flush_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      write_rq_q    <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      write_data_q  <= '0;
      upload_done_q <= 1'b0;
      frame_error_q <= 1'b0;
      addr_q        <= '0;
      pix_idx_q     <= '0;
      col_q         <= '0;
      row_q         <= '0;
      word_q        <= '0;
      pix_buf_q     <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      dec_wait_q    <= dec_wait_d;
      flush_q       <= flush_d;
      rd_en_q       <= rd_en_d;
      write_rq_q    <= write_rq_d;
      mem_wr_en_q   <= mem_wr_en_d;
      write_data_q  <= write_data_d;
      upload_done_q <= upload_done_d;
      frame_error_q <= frame_error_d;
      addr_q        <= addr_d;
      pix_idx_q     <= pix_idx_d;
      col_q         <= col_d;
      row_q         <= row_d;
      word_q        <= word_d;
      pix_buf_q     <= pix_buf_d;
    end
  end

endmodule

// File: tb/tb_frame_uploader.sv
// Bench for frame_uploader with a small 32x2 frame geometry.
module tb_frame_uploader;

  localparam int W = 32;
  localparam int H = 2;
`ifdef FRAME_UPLOADER_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] base_addr = '0;
  logic        queue_empty = 1'b1;
  logic [16:0] queue_data_i = '0;
  logic        queue_rd_en;
  logic        write_rq;
  logic        write_ack = 1'b0;
  logic [20:0] write_addr;
  logic [31:0] write_data;
  logic        mem_wr_en;
  logic        upload_done;
  logic        frame_error;

  frame_uploader #(.MEMORY_BURST(32), .FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .queue_empty(queue_empty),
    .queue_data_i(queue_data_i), .queue_rd_en(queue_rd_en), .write_rq(write_rq),
    .write_ack(write_ack), .write_addr(write_addr), .write_data(write_data),
    .mem_wr_en(mem_wr_en), .upload_done(upload_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int rd_viol = 0;
  bit ack_hold = 1'b0;

  logic [16:0] q_in[$];
  logic [20:0] sb_addr[$];
  logic [31:0] sb_word[$];

  logic [15:0] m_buf[16];
  int          m_idx = 0;
  logic [20:0] m_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // queue model: entry appears one cycle after the pop request
  initial begin
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (q_in.size() > 0) queue_data_i = q_in.pop_front();
          pend = 1'b0;
        end
        if (queue_rd_en) begin
          chk("rd_when_nonempty", 32'(q_in.size() > 0), 32'd1);
          pend = 1'b1;
        end
      end
      queue_empty = (q_in.size() == 0);
    end
  end

  // arbiter: grant as soon as a request is seen unless held off
  initial begin
    forever begin
      @(negedge clk);
      write_ack = write_rq && !mem_wr_en && !ack_hold && !reset;
    end
  end

  // output monitor against the scoreboard
  initial begin
    logic        prev_rq = 1'b0;
    logic [20:0] ea;
    logic [31:0] ew;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (write_rq && !prev_rq) begin
          ea = (sb_addr.size() > 0) ? sb_addr.pop_front() : 'x;
          chk("burst_addr", 32'(write_addr), 32'(ea));
        end
        if (mem_wr_en) begin
          ew = (sb_word.size() > 0) ? sb_word.pop_front() : 'x;
          chk("burst_word", write_data, ew);
        end
        if (write_rq && queue_rd_en) rd_viol++;
        if (upload_done) done_cnt++;
      end
      prev_rq = write_rq;
    end
  end

  task automatic push_entry(input logic [16:0] e);
    q_in.push_back(e);
    queue_empty = 1'b0;
  endtask

  task automatic push_burst();
    sb_addr.push_back(m_addr);
    for (int k = 0; k < 8; k++) sb_word.push_back({m_buf[2*k+1], m_buf[2*k]});
    m_addr = m_addr + 21'd16;
    m_idx = 0;
  endtask

  task automatic frame_start(input logic [20:0] base);
    base_addr = base;
    push_entry(17'h10000);
    m_addr = base;
    m_idx = 0;
  endtask

  task automatic row_start();
    push_entry(17'h10001);
  endtask

  task automatic pix(input logic [15:0] p);
    push_entry({1'b0, p});
    m_buf[m_idx] = p;
    m_idx++;
    if (m_idx == 16) push_burst();
  endtask

  task automatic frame_end();
    push_entry(17'h1FFFF);
    if (m_idx > 0) begin
      for (int i = m_idx; i < 16; i++) m_buf[i] = 16'h0000;
      push_burst();
    end
  endtask

  task automatic full_frame(input logic [20:0] base, input logic [15:0] seed, input bit marker);
    frame_start(base);
    for (int r = 0; r < H; r++) begin
      row_start();
      for (int c = 0; c < W; c++) begin
        pix(seed + 16'(r * 256 + c));
        if (marker && r == 0 && c == 10) push_entry(17'h1ABCD);
      end
    end
    frame_end();
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt - start), 32'd1);
    chk({tag, "_sb_drained"}, 32'(sb_word.size() + sb_addr.size()), 32'd0);
    chk({tag, "_frame_error"}, 32'(frame_error), 32'(exp_err));
  endtask

  initial begin
    int n;
    int guard;
    int dsnap;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_write_rq", 32'(write_rq), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rd_en", 32'(queue_rd_en), 32'd0);
    chk("rst_done", 32'(upload_done), 32'd0);
    chk("rst_error", 32'(frame_error), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    chk("rst_data", write_data, 32'd0);

    // single burst, pixels 1..16
    frame_start(21'h1000);
    row_start();
    for (int i = 1; i <= 16; i++) pix(16'(i));
    frame_end();
    wait_done("single", CK);

    // full frame with 21-bit address wrap
    full_frame(21'h1FFFF0, 16'h4000, 1'b0);
    wait_done("full_wrap", 1'b0);

    // partial burst flushed with zero padding
    frame_start(21'h0500);
    row_start();
    for (int i = 0; i < 5; i++) pix(16'hA000 + 16'(i));
    frame_end();
    wait_done("flush", CK);

    // grant withheld for 20 cycles with the queue still holding entries
    ack_hold = 1'b1;
    full_frame(21'h0800, 16'h1200, 1'b0);
    guard = 0;
    while (!write_rq && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("stall_rq_seen", 32'(write_rq), 32'd1);
    chk("stall_queue_nonempty", 32'(queue_empty), 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("stall_rq_held", 32'(write_rq), 32'd1);
      chk("stall_no_rd", 32'(queue_rd_en), 32'd0);
      chk("stall_no_data", 32'(mem_wr_en), 32'd0);
    end
    ack_hold = 1'b0;
    wait_done("stall", 1'b0);

    // reset during word 3 of a burst
    frame_start(21'h2000);
    row_start();
    for (int i = 0; i < 16; i++) pix(16'h7700 + 16'(i));
    frame_end();
    n = 0;
    guard = 0;
    while (n < 4 && guard < 2000) begin
      @(negedge clk);
      if (mem_wr_en) n++;
      guard++;
    end
    chk("reached_word3", 32'(n), 32'd4);
    dsnap = done_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q_in.delete();
    sb_word.delete();
    sb_addr.delete();
    queue_empty = 1'b1;
    m_idx = 0;
    @(negedge clk);
    chk("midrst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("midrst_write_rq", 32'(write_rq), 32'd0);
    chk("midrst_addr", 32'(write_addr), 32'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_resume", 32'(mem_wr_en), 32'd0);
    chk("midrst_no_done", 32'(done_cnt - dsnap), 32'd0);
    full_frame(21'h3000, 16'h0055, 1'b0);
    wait_done("after_rst", 1'b0);

    // unknown marker inside a row
    full_frame(21'h4000, 16'h9000, 1'b1);
    wait_done("unknown_marker", CK);

    chk("no_rd_during_write", 32'(rd_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
